ssd1306_spi_tx: RTL and testbench



---
 rtl/ssd1306_spi_tx.sv | 179 +++++++++++++++++
 tb/tb_ssd1306_spi_tx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ssd1306_spi_tx.sv
// ssd1306_spi_tx
// ----------------------------------------------------------------------------
// This is the SPI byte transmitter that sits between the microcode executor
// and the SSD1306 OLED pins. It sends each accepted byte MSB-first in SPI
// mode 0: SCLK idles low, MOSI is set up before each rising edge, and MOSI
// changes only on a falling edge. The block owns chip-select framing. CS stays
// low across a burst and is released after the byte that was flagged last,
// followed by a minimum deselect gap.
//
// Parameters
//   CLK_DIV     SCLK half-period in clk_in cycles (>=1); a byte takes
//               16*CLK_DIV cycles.
//   CS_TIMEOUT  Number of idle cycles with CS low before a forced deselect.
//               It is used only when the macro below is defined.
//
// Optional feature (macro SSD1306_SPI_CS_TIMEOUT_EN)
//   When this macro is defined, CS that is left low while idle is released
//   after CS_TIMEOUT cycles without an accept. The release uses the same
//   hold/gap sequence as a last byte.
//
// Ports
//   clk_in             system clock, rising edge
//   rstn_in            synchronous reset, active-low
//   spi_tx_trigger_in  level request to send; sampled only while ready
//   spi_data_in        byte to send, latched at accept
//   spi_last_byte_in   release CS after this byte, latched at accept
//   spi_ready_out      idle and able to accept a byte (combinational)
//   oled_sclk_out      SPI clock
//   oled_mosi_out      SPI data, MSB first
//   oled_csn_out       chip select, active-low
// ----------------------------------------------------------------------------
module ssd1306_spi_tx #(
  parameter int CLK_DIV    = 4,
  parameter int CS_TIMEOUT = 1024
) (
  input  logic       clk_in,
  input  logic       rstn_in,
  input  logic       spi_tx_trigger_in,
  input  logic [7:0] spi_data_in,
  input  logic       spi_last_byte_in,
  output logic       spi_ready_out,
  output logic       oled_sclk_out,
  output logic       oled_mosi_out,
  output logic       oled_csn_out
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_CS_HOLD,
    S_CS_GAP
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div_cnt;
  logic [2:0]       r_bit_cnt;
  logic [6:0]       r_shift;    // Bits still to send after the one on MOSI.
  logic             r_last;
  logic             r_sclk;
  logic             r_mosi;
  logic             r_csn;

  logic w_div_wrap;
  logic w_accept;
  logic w_timeout;

  assign w_div_wrap    = (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign w_accept      = (r_state == S_IDLE) && spi_tx_trigger_in;
  assign spi_ready_out = (r_state == S_IDLE);
  assign oled_sclk_out = r_sclk;
  assign oled_mosi_out = r_mosi;
  assign oled_csn_out  = r_csn;

`ifdef SSD1306_SPI_CS_TIMEOUT_EN
  localparam int TO_W = (CS_TIMEOUT > 1) ? $clog2(CS_TIMEOUT) : 1;

  logic [TO_W-1:0] r_to_cnt;

  // The timeout fires on the edge where the count would reach CS_TIMEOUT.
  // This releases CS CS_TIMEOUT+CLK_DIV cycles after the block goes idle.
  assign w_timeout = (r_state == S_IDLE) && !r_csn && !spi_tx_trigger_in &&
                     (r_to_cnt == TO_W'(CS_TIMEOUT - 1));

  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      r_to_cnt <= '0;
    end else if ((r_state == S_IDLE) && !r_csn && !w_accept && !w_timeout) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = ^CS_TIMEOUT;
`endif

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then updates from values sampled at the same edge, so the order of the
  // statements inside this block cannot change behaviour.
  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      r_state   <= S_IDLE;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_last    <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_csn     <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_div_cnt <= '0;
          if (w_accept) begin
            // If CS is already low from an earlier byte of the burst, it
            // simply stays low and no extra setup time is inserted.
            r_state   <= S_SHIFT;
            r_shift   <= spi_data_in[6:0];
            r_mosi    <= spi_data_in[7];
            r_last    <= spi_last_byte_in;
            r_bit_cnt <= '0;
            r_sclk    <= 1'b0;
            r_csn     <= 1'b0;
          end else if (w_timeout) begin
            r_state <= S_CS_HOLD;
          end
        end

        S_SHIFT: begin
          if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_sclk    <= ~r_sclk;
            // MOSI moves only on falling edges. The 8th falling edge ends the
            // byte instead of shifting.
            if (r_sclk) begin
              if (r_bit_cnt == 3'd7) begin
                r_state <= r_last ? S_CS_HOLD : S_IDLE;
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_mosi    <= r_shift[6];
                r_shift   <= {r_shift[5:0], 1'b0};
              end
            end
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end

        S_CS_HOLD: begin
          if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_csn     <= 1'b1;
            r_state   <= S_CS_GAP;
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end

        S_CS_GAP: begin
          if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_mosi    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ssd1306_spi_tx.sv
// tb_ssd1306_spi_tx
// ----------------------------------------------------------------------------
// This is a directed bench for ssd1306_spi_tx. It has two instances:
//   u_dut0  CLK_DIV=2, the default CS_TIMEOUT
//   u_dut1  CLK_DIV=1, CS_TIMEOUT=8
// The sel signal routes the trigger to one instance and picks which
// instance's outputs are observed. Inputs are driven on negedges and outputs
// are sampled on negedges. Cycle n=1 is the first cycle after the accept edge.
// ----------------------------------------------------------------------------
module tb_ssd1306_spi_tx;

  logic       clk_in = 1'b0;
  logic       rstn_in;
  logic       trig;
  logic       sel;
  logic [7:0] data;
  logic       last;

  logic trig0, trig1;
  logic rdy0, sclk0, mosi0, csn0;
  logic rdy1, sclk1, mosi1, csn1;
  logic w_ready, w_sclk, w_mosi, w_csn;

  int vectors     = 0;
  int miscompares = 0;

  // Results recorded by observe()
  int           rise_cnt;
  int           rise_at [16];
  logic [15:0]  bits;
  int           last_fall;
  int           csn_first_hi;
  int           ready_first;
  logic [127:0] rdy_h;

  always #5 clk_in = ~clk_in;

  assign trig0   = trig & ~sel;
  assign trig1   = trig &  sel;
  assign w_ready = sel ? rdy1  : rdy0;
  assign w_sclk  = sel ? sclk1 : sclk0;
  assign w_mosi  = sel ? mosi1 : mosi0;
  assign w_csn   = sel ? csn1  : csn0;

  ssd1306_spi_tx #(.CLK_DIV(2)) u_dut0 (
    .clk_in            (clk_in),
    .rstn_in           (rstn_in),
    .spi_tx_trigger_in (trig0),
    .spi_data_in       (data),
    .spi_last_byte_in  (last),
    .spi_ready_out     (rdy0),
    .oled_sclk_out     (sclk0),
    .oled_mosi_out     (mosi0),
    .oled_csn_out      (csn0)
  );

  ssd1306_spi_tx #(.CLK_DIV(1), .CS_TIMEOUT(8)) u_dut1 (
    .clk_in            (clk_in),
    .rstn_in           (rstn_in),
    .spi_tx_trigger_in (trig1),
    .spi_data_in       (data),
    .spi_last_byte_in  (last),
    .spi_ready_out     (rdy1),
    .oled_sclk_out     (sclk1),
    .oled_mosi_out     (mosi1),
    .oled_csn_out      (csn1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // The caller sets up data, last and trig at a negedge. This task then
  // watches ncyc cycles and records the SCLK rising edges with the MOSI value
  // at each one, the last falling edge, and the first CS-high and ready cycles.
  //   n==1        data and last switch to chg_data and chg_last. This shows
  //               that changes after accept are ignored.
  //   n==drop_at  trig is dropped.
  //   n==pulse_at trig pulses for one cycle with different data.
  task automatic observe(input int ncyc, input int drop_at, input int pulse_at,
                         input logic [7:0] chg_data, input logic chg_last);
    logic prev;
    prev         = w_sclk;
    rise_cnt     = 0;
    bits         = '0;
    last_fall    = 0;
    csn_first_hi = 0;
    ready_first  = 0;
    rdy_h        = '0;
    for (int i = 0; i < 16; i++) rise_at[i] = 0;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk_in);
      if (w_sclk && !prev) begin
        if (rise_cnt < 16) begin
          rise_at[rise_cnt] = n;
          bits = {bits[14:0], w_mosi};
        end
        rise_cnt++;
      end
      if (!w_sclk && prev) last_fall = n;
      prev = w_sclk;
      if (w_csn && csn_first_hi == 0) csn_first_hi = n;
      if (w_ready && ready_first == 0) ready_first = n;
      if (n < 128) rdy_h[n] = w_ready;
      if (n == 1) begin
        data = chg_data;
        last = chg_last;
      end
      if (n == drop_at || (pulse_at != 0 && n == pulse_at + 1)) trig = 1'b0;
      if (n == pulse_at) begin
        trig = 1'b1;
        data = 8'hFF;
        last = 1'b0;
      end
    end
  endtask

  initial begin
    int csn_hi_cycles;
    rstn_in = 1'b0;
    trig    = 1'b0;
    sel     = 1'b0;
    data    = 8'h00;
    last    = 1'b0;
    repeat (3) @(negedge clk_in);

    // Reset state
    check("rst_ready", {31'd0, rdy0}, 32'd1);
    check("rst_csn",   {31'd0, csn0}, 32'd1);
    check("rst_sclk",  {31'd0, sclk0}, 32'd0);
    check("rst_mosi",  {31'd0, mosi0}, 32'd0);
    check("rst_csn1",  {31'd0, csn1}, 32'd1);
    rstn_in = 1'b1;
    @(negedge clk_in);

    // 1) 0xA5 last=1, CLK_DIV=2
    data = 8'hA5; last = 1'b1; trig = 1'b1;
    observe(40, 1, 0, 8'hA5, 1'b1);
    check("a5_ready_t1", {31'd0, rdy_h[1]}, 32'd0);
    check("a5_rises",    rise_cnt, 8);
    check("a5_rise0",    rise_at[0], 3);
    check("a5_rise7",    rise_at[7], 31);
    check("a5_bits",     {24'd0, bits[7:0]}, 32'h A5);
    check("a5_lastfall", last_fall, 33);
    check("a5_csn_hi",   csn_first_hi, 35);
    check("a5_ready",    ready_first, 37);
    check("a5_mosi_end", {31'd0, w_mosi}, 32'd0);

    // 2) 0x3C last=0, then 0xAF last=1. The trigger is held so 0xAF is taken
    //    at the ready rise; data and last change right after the first accept.
    data = 8'h3C; last = 1'b0; trig = 1'b1;
    observe(72, 34, 0, 8'hAF, 1'b1);
    check("b2b_rises",    rise_cnt, 16);
    check("b2b_bits",     {16'd0, bits}, 32'h3CAF);
    check("b2b_rise7",    rise_at[7], 31);
    check("b2b_rise8",    rise_at[8], 36);
    check("b2b_ready33",  {31'd0, rdy_h[33]}, 32'd1);
    check("b2b_ready34",  {31'd0, rdy_h[34]}, 32'd0);
    check("b2b_lastfall", last_fall, 66);
    check("b2b_csn_hi",   csn_first_hi, 68);
    check("b2b_ready69",  {31'd0, rdy_h[69]}, 32'd0);
    check("b2b_ready70",  {31'd0, rdy_h[70]}, 32'd1);

    // 3) 0x5A last=1 with a trigger pulse mid-byte that must be ignored.
    data = 8'h5A; last = 1'b1; trig = 1'b1;
    observe(40, 1, 10, 8'h00, 1'b0);
    check("pulse_rises",  rise_cnt, 8);
    check("pulse_bits",   {24'd0, bits[7:0]}, 32'h5A);
    check("pulse_csn_hi", csn_first_hi, 35);
    check("pulse_ready",  ready_first, 37);

    // 4) Reset mid-byte while SCLK and MOSI are both high, then send 0x81.
    data = 8'hFF; last = 1'b0; trig = 1'b1;
    observe(7, 1, 0, 8'hFF, 1'b0);
    check("pre_rst_sclk", {31'd0, w_sclk}, 32'd1);
    check("pre_rst_mosi", {31'd0, w_mosi}, 32'd1);
    rstn_in = 1'b0;
    @(negedge clk_in);
    rstn_in = 1'b1;
    check("midrst_csn",   {31'd0, w_csn}, 32'd1);
    check("midrst_sclk",  {31'd0, w_sclk}, 32'd0);
    check("midrst_mosi",  {31'd0, w_mosi}, 32'd0);
    check("midrst_ready", {31'd0, w_ready}, 32'd1);
    data = 8'h81; last = 1'b1; trig = 1'b1;
    observe(40, 1, 0, 8'h81, 1'b1);
    check("x81_rises",  rise_cnt, 8);
    check("x81_bits",   {24'd0, bits[7:0]}, 32'h81);
    check("x81_csn_hi", csn_first_hi, 35);
    check("x81_ready",  ready_first, 37);

    // 5) CLK_DIV=1: 0xC3 last=1
    sel = 1'b1;
    @(negedge clk_in);
    data = 8'hC3; last = 1'b1; trig = 1'b1;
    observe(22, 1, 0, 8'hC3, 1'b1);
    check("d1_rises",    rise_cnt, 8);
    check("d1_bits",     {24'd0, bits[7:0]}, 32'hC3);
    check("d1_rise0",    rise_at[0], 2);
    check("d1_rise7",    rise_at[7], 16);
    check("d1_lastfall", last_fall, 17);
    check("d1_csn_hi",   csn_first_hi, 18);
    check("d1_ready",    ready_first, 19);

    // 6) CLK_DIV=1: 0x00 last=0, then no further trigger
    data = 8'h00; last = 1'b0; trig = 1'b1;
    observe(30, 1, 0, 8'h00, 1'b0);
    check("to_rises", rise_cnt, 8);
    check("to_ready", ready_first, 17);
`ifdef SSD1306_SPI_CS_TIMEOUT_EN
    check("to_csn_hi",  csn_first_hi, 26);
    check("to_ready24", {31'd0, rdy_h[24]}, 32'd1);
    check("to_ready25", {31'd0, rdy_h[25]}, 32'd0);
    check("to_ready26", {31'd0, rdy_h[26]}, 32'd0);
    check("to_ready27", {31'd0, rdy_h[27]}, 32'd1);
    check("to_sclk",    {31'd0, w_sclk}, 32'd0);
`else
    check("nto_csn_hi", csn_first_hi, 0);
    csn_hi_cycles = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_in);
      if (w_csn) csn_hi_cycles++;
    end
    check("nto_csn_1000", csn_hi_cycles, 0);
    check("nto_ready",    {31'd0, w_ready}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
